// File: rtl/fetch_controller_if.sv
// Instruction-memory request/response and IF/ID slot signals of the fetch controller.
interface fetch_controller_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ready, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ready, imem_rvalid, imem_rdata, id_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: one outstanding imem request, IF/ID slot with a
// one-entry skid buffer, and redirect handling that discards in-flight words.
module fetch_controller #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] PC_INITIAL = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    output logic            pc_sel,
    output logic            fetch_enable,
    output logic            fetch_stall,
    output logic            fetch_busy,
    fetch_controller_if.master bus
);

    localparam logic [XLEN-1:0] NOP = {{(XLEN-7){1'b0}}, 7'h13};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t          state;
    logic            armed;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic            slot_valid;
    logic [XLEN-1:0] slot_instr;
    logic [XLEN-1:0] slot_pc;

    logic ctl_en;
    logic redir;
    logic hs;
    logic slot_free;
    logic wait_rsp;
    logic load_mem;
    logic store_skid;
    logic load_skid;

    // Controls stay quiet during reset and for the single cycle after it.
    assign ctl_en     = armed & ~reset;
    assign redir      = redirect_valid & ctl_en;
    assign hs         = bus.imem_req & bus.imem_ready;
    assign slot_free  = ~slot_valid | bus.id_ready;
    assign wait_rsp   = (state == S_WAIT) & bus.imem_rvalid & ~redir;
    assign load_mem   = wait_rsp & slot_free;
    assign store_skid = wait_rsp & ~slot_free;
    assign load_skid  = (state == S_HOLD) & bus.id_ready & ~redir;

    assign pc_sel       = redir;
    assign fetch_enable = redir | (ctl_en & (load_mem | load_skid));
    assign fetch_stall  = ctl_en & slot_valid & ~bus.id_ready & ~redirect_valid;
    assign fetch_busy   = ctl_en & (state != S_IDLE) & ~fetch_enable;

    assign bus.imem_req  = ctl_en & (state == S_REQ);
    assign bus.imem_addr = pc;
    assign bus.if_valid  = slot_valid;
    assign bus.if_instr  = slot_instr;
    assign bus.if_pc     = slot_pc;

    // Fetch sequencer: request, wait for the word, park it if decode is stalled,
    // or drain a response that a redirect made stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (run) state <= S_REQ;
                end
                S_REQ: begin
                    if (hs) begin
                        req_pc <= pc;
                        state  <= redir ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (redir)          state <= S_REQ;
                        else if (slot_free) state <= run ? S_REQ : S_IDLE;
                        else                state <= S_HOLD;
                    end else if (redir) begin
                        state <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (redir)             state <= S_REQ;
                    else if (bus.id_ready) state <= run ? S_REQ : S_IDLE;
                end
                S_DRAIN: begin
                    if (bus.imem_rvalid) state <= run ? S_REQ : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // IF/ID slot: redirect flushes, then a fresh word or the skid word loads,
    // otherwise a consumed slot empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= 1'b0;
            slot_instr <= NOP;
            slot_pc    <= PC_INITIAL;
        end else if (redir) begin
            slot_valid <= 1'b0;
        end else if (load_mem) begin
            slot_valid <= 1'b1;
            slot_instr <= bus.imem_rdata;
            slot_pc    <= req_pc;
        end else if (load_skid) begin
            slot_valid <= 1'b1;
            slot_instr <= skid_instr;
            slot_pc    <= skid_pc;
        end else if (slot_valid & bus.id_ready) begin
            slot_valid <= 1'b0;
        end
    end

    // Skid buffer captures a response that arrives while decode holds the slot.
    always_ff @(posedge clk) begin
        if (store_skid) begin
            skid_instr <= bus.imem_rdata;
            skid_pc    <= req_pc;
        end
    end

endmodule
